// File: rtl/l0_loader.sv
// l0_loader: streams `len` consecutive SRAM words into the L0 row-FIFO bank.
// A 2-entry skid absorbs the 1-cycle SRAM read latency under L0 backpressure.
module l0_loader #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   base_addr,
  input  logic [addr_w:0]     len,
  output logic                busy,
  output logic                done,
  output logic                sram_cen,
  output logic [addr_w-1:0]   sram_addr,
  input  logic [row*bw-1:0]   sram_q,
  input  logic                l0_full,
  output logic                l0_wr,
  output logic [row*bw-1:0]   l0_in
);
  localparam int W = row * bw;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [addr_w-1:0] addr_q, addr_d;
  logic [addr_w:0]   rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0][W-1:0] skid_q, skid_d;

  logic pop, push, issue, room;
  logic [1:0] slot;

  assign pop   = (cnt_q != 2'd0) && !l0_full;
  assign push  = inflight_q;
  // Free slots once this edge's pop and landing word are accounted for.
  assign room  = ({1'b0, cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
  assign issue = (state_q == S_READ) && !l0_full && (rem_q != '0) && room;
  assign slot  = cnt_q - {1'b0, pop};

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sram_cen  = !issue;
  assign sram_addr = issue ? addr_q : '0;
  assign l0_wr     = pop;
  assign l0_in     = skid_q[0];

  // Skid FIFO update: shift head out on pop, land the returning word behind it.
  always_comb begin
    skid_d = skid_q;
    if (pop) skid_d[0] = skid_q[1];
    if (push) skid_d[slot[0]] = sram_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Control FSM, address/remaining counters and in-flight tracking.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = issue;
    if (issue) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
    case (state_q)
      S_IDLE: if (start) begin
        addr_d  = base_addr;
        rem_d   = len;
        state_d = (len == '0) ? S_DONE : S_READ;
      end
      S_READ:  if (issue && rem_q == 1) state_d = S_DRAIN;
      // Leave as soon as the last word is written so done trails it by one cycle.
      S_DRAIN: if (cnt_d == 2'd0 && !inflight_d) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any word still in flight from the SRAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      skid_q     <= skid_d;
    end
  end
endmodule

// File: tb/tb_l0_loader.sv
// Directed bench for l0_loader with a 1-cycle-latency SRAM model.
module tb_l0_loader;
  logic        clk = 0, reset = 0, start = 0, l0_full = 0;
  logic [10:0] base_addr = 0;
  logic [11:0] len = 0;
  logic        busy, done, sram_cen, l0_wr;
  logic [10:0] sram_addr;
  logic [31:0] sram_q = 0, l0_in;

  int n_tests = 0, n_fail = 0;
  int iss_addr[$], iss_cyc[$], wr_cyc[$], done_cyc[$];
  logic [31:0] wr_dat[$];
  bit busy_at[0:63];
  int max_occ, n_iss, n_wr, iss_4_8, wr_4_8;

  l0_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_cen(sram_cen), .sram_addr(sram_addr),
    .sram_q(sram_q), .l0_full(l0_full), .l0_wr(l0_wr), .l0_in(l0_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wd(input int a);
    logic [31:0] v;
    v = a;
    return {20'hA5A5A, v[11:0]};
  endfunction

  // SRAM: data for the address issued this cycle appears next cycle.
  always @(posedge clk) if (!sram_cen) sram_q <= wd(int'(sram_addr));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cen"}, sram_cen, 1);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_wr"}, l0_wr, 0);
    chk({tag, "_in"}, l0_in, 0);
  endtask

  task automatic run(input int base, input int ln, input int ncyc, input int fl, input int fh,
                     input int rs_cyc, input int rs_base, input int rs_len, input int rst_cyc);
    iss_addr.delete(); iss_cyc.delete(); wr_cyc.delete(); wr_dat.delete(); done_cyc.delete();
    for (int i = 0; i < 64; i++) busy_at[i] = 0;
    max_occ = 0; n_iss = 0; n_wr = 0; iss_4_8 = 0; wr_4_8 = 0;
    @(negedge clk);
    start = 1; base_addr = 11'(base); len = 12'(ln);
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= ncyc; c++) begin
      l0_full = (c >= fl && c <= fh);
      if (c == rs_cyc) begin start = 1; base_addr = 11'(rs_base); len = 12'(rs_len); end
      if (c == rst_cyc) begin
        #2 reset = 0;
        #1 chk_reset_outs("midrst");
        reset = 1;
        n_iss = 0; n_wr = 0;
      end
      @(negedge clk);
      if (n_iss - n_wr > max_occ) max_occ = n_iss - n_wr;
      busy_at[c] = busy;
      if (!sram_cen) begin
        iss_addr.push_back(int'(sram_addr)); iss_cyc.push_back(c); n_iss++;
        if (c >= 4 && c <= 8) iss_4_8++;
      end
      if (l0_wr) begin
        wr_cyc.push_back(c); wr_dat.push_back(l0_in); n_wr++;
        if (c >= 4 && c <= 8) wr_4_8++;
      end
      if (done) done_cyc.push_back(c);
      @(posedge clk); #1;
      start = 0;
    end
    l0_full = 0;
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic longint qd(input int i);
    return (i < wr_dat.size()) ? longint'(wr_dat[i]) : -1;
  endfunction

  initial begin
    int exp_a[4];
    #12 chk_reset_outs("rst");
    reset = 1;

    // Basic unthrottled burst.
    run(16, 4, 10, 0, 0, 0, 0, 0, 0);
    chk("t1_niss", iss_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_iaddr", qi(iss_addr, i), 16 + i);
      chk("t1_icyc", qi(iss_cyc, i), 1 + i);
      chk("t1_wcyc", qi(wr_cyc, i), 3 + i);
      chk("t1_wdat", qd(i), longint'(wd(16 + i)));
    end
    chk("t1_nwr", wr_cyc.size(), 4);
    chk("t1_ndone", done_cyc.size(), 1);
    chk("t1_donecyc", qi(done_cyc, 0), 7);
    chk("t1_busy1", busy_at[1], 1);
    chk("t1_busy8", busy_at[8], 0);

    // Zero-length request.
    run(5, 0, 6, 0, 0, 0, 0, 0, 0);
    chk("t2_niss", iss_addr.size(), 0);
    chk("t2_nwr", wr_cyc.size(), 0);
    chk("t2_ndone", done_cyc.size(), 1);
    chk("t2_donecyc", qi(done_cyc, 0), 1);
    chk("t2_busy1", busy_at[1], 1);
    chk("t2_busy2", busy_at[2], 0);

    // Backpressure mid-burst, cycles 4..8.
    run(0, 8, 24, 4, 8, 0, 0, 0, 0);
    chk("t3_nwr", wr_cyc.size(), 8);
    for (int i = 0; i < 8; i++) chk("t3_wdat", qd(i), longint'(wd(i)));
    chk("t3_occ_gt2", max_occ > 2, 0);
    chk("t3_iss4_8", iss_4_8, 0);
    chk("t3_wr4_8", wr_4_8, 0);
    chk("t3_resume", qi(wr_cyc, 1), 9);
    chk("t3_ndone", done_cyc.size(), 1);

    // Address wrap.
    run(2046, 4, 10, 0, 0, 0, 0, 0, 0);
    exp_a = '{2046, 2047, 0, 1};
    chk("t4_nwr", wr_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_iaddr", qi(iss_addr, i), exp_a[i]);
      chk("t4_wdat", qd(i), longint'(wd(exp_a[i])));
    end

    // Second start while busy is ignored.
    run(40, 6, 16, 0, 0, 2, 300, 3, 0);
    chk("t5_nwr", wr_cyc.size(), 6);
    for (int i = 0; i < 6; i++) chk("t5_wdat", qd(i), longint'(wd(40 + i)));
    chk("t5_ndone", done_cyc.size(), 1);

    // Async reset in cycle 3, then a fresh short transfer.
    run(0, 8, 12, 0, 0, 0, 0, 0, 3);
    chk("t6_nwr", wr_cyc.size(), 0);
    chk("t6_ndone", done_cyc.size(), 0);
    chk("t6_busyend", busy_at[12], 0);
    run(100, 2, 8, 0, 0, 0, 0, 0, 0);
    chk("t6_nwr2", wr_cyc.size(), 2);
    chk("t6_wdat0", qd(0), longint'(wd(100)));
    chk("t6_wdat1", qd(1), longint'(wd(101)));
    chk("t6_ndone2", done_cyc.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/l0_loader.md
Name: l0_loader

Overview:
- Upstream feeder for the L0 row-FIFO bank.
- Reads `len` consecutive activation/weight words from the activation SRAM, starting at `base_addr`, and pushes them into L0 one word per cycle.
- Obeys L0's `o_full` backpressure. A 2-entry skid buffer absorbs the 1-cycle SRAM read latency, so no word is lost or duplicated when L0 fills mid-burst.

Parameters:
row, 8, number of L0 rows; word width is row*bw
bw, 4, bits per row element
addr_w, 11, SRAM address width

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  1-cycle request pulse; sampled only in IDLE
base_addr  in  addr_w  first SRAM address; sampled with start
len  in  addr_w+1  number of words to transfer; sampled with start
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  1-cycle pulse in DONE state
sram_cen  out  1  SRAM chip enable, active-low; 0 = read issued this cycle
sram_addr  out  addr_w  SRAM read address
sram_q  in  row*bw  SRAM read data; valid exactly 1 cycle after the issuing cycle
l0_full  in  1  L0 o_full
l0_wr  out  1  L0 write strobe
l0_in  out  row*bw  L0 write data (skid head)

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; busy=0, done=0, sram_cen=1, sram_addr=0, l0_wr=0, l0_in=0.
  - Skid count=0, skid entries=0, inflight=0, remaining=0.
  - Any in-flight SRAM data is discarded: inflight is cleared, so the next sram_q is not captured.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start=1, latch addr<=base_addr and remaining<=len.
  - If len==0, go to DONE; otherwise go to READ.
- READ:
  - pop = l0_wr.
  - Issue condition: !l0_full && remaining>0 && (2 - cnt - inflight + pop) > 0.
  - On issue: sram_cen=0, sram_addr=addr, addr<=addr+1 (mod 2^addr_w), remaining<=remaining-1, inflight<=1.
  - No issue: inflight<=0 and sram_cen=1.
  - When the issue that makes remaining reach 0 occurs, go to DRAIN.
- DRAIN: no issues. When cnt==0 and inflight==0, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- busy: 1 in READ, DRAIN and DONE.
- start outside IDLE is ignored.
- Capture: if inflight==1 at a rising edge, sram_q is pushed into the skid at that edge. The push occurs in the same edge as any pop.
- Skid buffer:
  - 2-entry FIFO; l0_in = head entry.
  - l0_wr = (cnt>0) && !l0_full. This is combinational on l0_full.
  - A simultaneous push and pop leaves cnt unchanged.
- The free-slot rule above guarantees no push ever occurs with cnt==2.
- Word order into L0 equals SRAM address order.
- Throughput and latency:
  - 1 word/cycle while l0_full=0.
  - start accepted at edge 0 → first issue in cycle 1 → first l0_wr=1 in cycle 3.
  - done pulse occurs 1 cycle after the last l0_wr when unthrottled.
- l0_full asserting:
  - Issues stop the same cycle.
  - At most 1 in-flight word still lands in the skid; skid occupancy ≤2.
  - Writes resume the first cycle l0_full=0.
- Address wrap-around is silent, modulo 2^addr_w.

Test Plan:
- base_addr=16, len=4, l0_full=0, SRAM[k]=k → sram_addr 16,17,18,19 in cycles 1–4; l0_wr=1 in cycles 3–6 carrying 16..19; done pulse in cycle 7; busy=0 in cycle 8.
- len=0 start → no sram_cen=0, no l0_wr; done=1 in cycle 1; busy=1 only in cycle 1.
- len=8, l0_full forced 1 for cycles 4–8 → exactly 8 writes, data 0..7 in order, never 3 words buffered, sram_cen=1 throughout cycles 4–8, resume in cycle 9.
- base_addr=2046, len=4 (addr_w=11) → addresses 2046, 2047, 0, 1; 4 writes in that order.
- start pulsed again in cycle 2 of a len=6 transfer → ignored; exactly 6 writes, one done.
- reset=0 asynchronously in cycle 3 of a len=8 transfer → outputs at reset values immediately; after release no l0_wr from the stale in-flight word; a new start (len=2) transfers 2 words correctly.
